// File: rtl/axil_triggered_writer.sv
// Replays a programmed table of AXI-lite register writes each time a trigger pulse arrives.
// Latency: awvalid/wvalid rise the cycle after the trigger edge; done pulses the cycle after the last bvalid.
// Backpressure: each valid holds until its ready, bready holds until bvalid; triggers while active are dropped with an overrun pulse.
module axil_triggered_writer #(
    parameter int N_WRITES   = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_W     = (N_WRITES > 1) ? $clog2(N_WRITES) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      trigger,
    input  logic                      cfg_we,
    input  logic                      cfg_sel_count,
    input  logic [IDX_W-1:0]          cfg_index,
    input  logic [ADDR_WIDTH-1:0]     cfg_address,
    input  logic [DATA_WIDTH-1:0]     cfg_data,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      overrun,
    // write address channel
    output logic                      awvalid,
    input  logic                      awready,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [2:0]                awprot,
    // write data channel
    output logic                      wvalid,
    input  logic                      wready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    // write response channel
    input  logic                      bvalid,
    output logic                      bready,
    input  logic [1:0]                bresp,
    // read channels, unused by this initiator
    output logic                      arvalid,
    input  logic                      arready,
    output logic [ADDR_WIDTH-1:0]     araddr,
    output logic [2:0]                arprot,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RESP   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Length needs one extra bit so that a full table (N_WRITES) is representable.
    localparam logic [IDX_W:0] N_MAX = (IDX_W+1)'(N_WRITES);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W:0]          len;
    logic                    aw_done;
    logic                    w_done;
    logic                    fin_busy;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    idx_last;
    logic                    cfg_ok;

    logic [ADDR_WIDTH-1:0]   tab_addr [N_WRITES];
    logic [DATA_WIDTH-1:0]   tab_data [N_WRITES];

    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign idx_last = ({1'b0, idx} == (len - 1'b1));
    assign cfg_ok   = cfg_we && !busy;

    // Channel outputs: table entry at the current index, each valid until its own handshake.
    assign awvalid = (state == ISSUE) && !aw_done;
    assign wvalid  = (state == ISSUE) && !w_done;
    assign awaddr  = tab_addr[idx];
    assign wdata   = tab_data[idx];
    assign bready  = (state == RESP);
    assign awprot  = 3'b000;
    assign wstrb   = '1;
    assign done    = (state == FINISH);
    // A zero-length sequence passes through FINISH without ever looking busy.
    assign busy    = (state == ISSUE) || (state == RESP) || ((state == FINISH) && fin_busy);

    assign arvalid = 1'b0;
    assign araddr  = '0;
    assign arprot  = 3'b000;
    assign rready  = 1'b0;

    logic unused_rd;
    assign unused_rd = ^{arready, rvalid, rdata, rresp};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one write in flight, advance after both AW and W have handshaken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = (len != '0) ? ISSUE : FINISH;
                end
            end
            ISSUE: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bvalid) begin
                    state_nxt = idx_last ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Sequence bookkeeping, status flags and the length register.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx      <= '0;
            len      <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            fin_busy <= 1'b0;
            error    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= trigger && (state != IDLE);
            case (state)
                IDLE: begin
                    fin_busy <= 1'b0;
                    if (trigger && (len != '0)) begin
                        idx     <= '0;
                        error   <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                RESP: begin
                    if (bvalid) begin
                        if (bresp != 2'b00) error <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (idx_last) begin
                            fin_busy <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    fin_busy <= 1'b0;
                end
                default: begin
                    fin_busy <= 1'b0;
                end
            endcase
            if (cfg_ok && cfg_sel_count) begin
                len <= (cfg_data > DATA_WIDTH'(N_WRITES)) ? N_MAX : cfg_data[IDX_W:0];
            end
        end
    end

    // Write table: not reset, only writable while idle, out-of-range indices ignored.
    always_ff @(posedge clock) begin
        if (cfg_ok && !cfg_sel_count && ({1'b0, cfg_index} < N_MAX)) begin
            tab_addr[cfg_index] <= cfg_address;
            tab_data[cfg_index] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_axil_triggered_writer.sv
`timescale 1ns/1ps
module tb_axil_triggered_writer;
    localparam int N = 8;

    logic        clock = 1'b0;
    logic        reset, trigger, cfg_we, cfg_sel_count;
    logic [2:0]  cfg_index;
    logic [31:0] cfg_address, cfg_data;
    logic        busy, done, error, overrun;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        arready, rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    assign arready = 1'b0;
    assign rvalid  = 1'b0;
    assign rdata   = 32'h0;
    assign rresp   = 2'b00;

    axil_triggered_writer #(.N_WRITES(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .trigger(trigger),
        .cfg_we(cfg_we), .cfg_sel_count(cfg_sel_count), .cfg_index(cfg_index),
        .cfg_address(cfg_address), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .overrun(overrun),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- slave model and monitor (negedge) ----------------
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [1:0]  resp_plan [256];
    int aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
    bit aw_hs_p = 0, w_hs_p = 0, b_hs_p = 0, aw_got = 0, w_got = 0;
    bit aw_prev_v = 0, w_prev_v = 0;
    logic [31:0] aw_cap, w_cap, aw_prev, w_prev;
    int b_total = 0, done_total = 0, ovr_total = 0, b_last_cyc = 0, done_last_cyc = 0;
    int stab_viol = 0, early_b = 0, aw_hi = 0, w_hi = 0, bad_fixed = 0;

    always @(negedge clock) begin
        if (aw_hs_p) begin obs_addr.push_back(aw_cap); aw_got = 1; aw_cnt = 0; end
        if (w_hs_p)  begin obs_data.push_back(w_cap);  w_got = 1;  w_cnt = 0;  end
        if (b_hs_p)  begin bvalid = 0; b_total++; end
        if (done)    begin done_total++; done_last_cyc = cyc; end
        if (overrun) ovr_total++;
        if (awvalid) aw_hi++;
        if (wvalid)  w_hi++;
        if (bready && (awvalid || wvalid)) early_b++;
        if (aw_prev_v && !aw_hs_p && awvalid && (awaddr !== aw_prev)) stab_viol++;
        if (w_prev_v && !w_hs_p && wvalid && (wdata !== w_prev)) stab_viol++;
        if (wstrb !== 4'hF || awprot !== 3'b000 || araddr !== 32'h0 || arvalid !== 1'b0 || rready !== 1'b0)
            bad_fixed++;
        if (reset) begin aw_got = 0; w_got = 0; bvalid = 0; aw_cnt = 0; w_cnt = 0; end
        awready = 0;
        if (awvalid) begin if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++; end
        wready = 0;
        if (wvalid) begin if (w_cnt >= w_dly) wready = 1; else w_cnt++; end
        if (aw_got && w_got && !bvalid && !reset) begin
            bvalid = 1; bresp = resp_plan[b_total % 256]; aw_got = 0; w_got = 0;
        end
        aw_hs_p = awvalid && awready; aw_cap = awaddr;
        w_hs_p  = wvalid && wready;   w_cap  = wdata;
        b_hs_p  = bvalid && bready;
        if (b_hs_p) b_last_cyc = cyc;
        aw_prev_v = awvalid; aw_prev = awaddr;
        w_prev_v  = wvalid;  w_prev  = wdata;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_addr [N];
    logic [31:0] m_data [N];
    int m_len = 0;
    bit m_err = 0;

    task automatic tick;
        @(posedge clock); #2;
    endtask

    task automatic cfg_entry(input int i, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1; cfg_sel_count = 0; cfg_index = i[2:0]; cfg_address = a; cfg_data = d;
        tick; cfg_we = 0;
        m_addr[i] = a; m_data[i] = d;
    endtask

    task automatic cfg_len(input int v);
        cfg_we = 1; cfg_sel_count = 1; cfg_index = 0; cfg_address = 0; cfg_data = v;
        tick; cfg_we = 0; cfg_sel_count = 0;
        m_len = (v > N) ? N : v;
    endtask

    // Number of writes that differ from the model's expected sequence since the snapshot.
    function automatic int seq_bad(input int sa, input int sd);
        int bad = 0;
        if ((obs_addr.size() - sa) != m_len || (obs_data.size() - sd) != m_len) return 1000;
        for (int j = 0; j < m_len; j++)
            if (obs_addr[sa+j] !== m_addr[j] || obs_data[sd+j] !== m_data[j]) bad++;
        return bad;
    endfunction

    task automatic run_seq(output bit first_aw, output bit err_t1, output bit busy_ok,
                           output bit got_done, output int lat);
        first_aw = 0; err_t1 = 0; busy_ok = 1; got_done = 0; lat = 0;
        trigger = 1; tick; trigger = 0;
        first_aw = awvalid; err_t1 = error;
        for (int i = 0; i < 400 && !got_done; i++) begin
            if (m_len > 0 && !busy) busy_ok = 0;
            if (done) got_done = 1;
            else begin tick; lat++; end
        end
        tick; tick;
    endtask

    bit fa, et, bo, gd;
    int lat, sa, sd, dt, ah, wh, eb, sv;

    task automatic snap;
        sa = obs_addr.size(); sd = obs_data.size(); dt = done_total;
        ah = aw_hi; wh = w_hi; eb = early_b; sv = stab_viol;
    endtask

    task automatic test_reset;
        reset = 1; tick; tick; tick;
        n_checks++;
        if ({busy, done, error, overrun, awvalid, wvalid, bready, arvalid, rready} !== 9'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 000000000",
                {busy, done, error, overrun, awvalid, wvalid, bready, arvalid, rready});
        end
        reset = 0; m_len = 0; m_err = 0; tick;
        snap; run_seq(fa, et, bo, gd, lat);
        n_checks++;
        if (gd !== 1'b1 || (obs_addr.size() - sa) != 0) begin
            n_fail++; $display("FAIL reset_len_zero: done=%0d writes=%0d expected done=1 writes=0", gd, obs_addr.size() - sa);
        end
    endtask

    task automatic test_basic;
        aw_dly = 0; w_dly = 0;
        cfg_len(2);
        cfg_entry(0, 32'h43C0_0004, 32'd100);
        cfg_entry(1, 32'h43C0_0008, 32'd25);
        snap; run_seq(fa, et, bo, gd, lat);
        n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL basic_done_seen: got %0d expected 1", gd); end
        n_checks++; if (fa !== 1'b1) begin n_fail++; $display("FAIL basic_awvalid_t1: got %0d expected 1", fa); end
        n_checks++; if (seq_bad(sa, sd) != 0) begin n_fail++; $display("FAIL basic_writes: %0d bad entries expected 0", seq_bad(sa, sd)); end
        n_checks++; if (done_total - dt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_total - dt); end
        n_checks++; if (done_last_cyc != b_last_cyc + 1) begin n_fail++; $display("FAIL basic_done_timing: done at %0d expected %0d", done_last_cyc, b_last_cyc + 1); end
        n_checks++; if (bo !== 1'b1) begin n_fail++; $display("FAIL basic_busy_held: got %0d expected 1", bo); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %0d expected 0", error); end
        n_checks++; if (bad_fixed != 0) begin n_fail++; $display("FAIL basic_fixed_channels: got %0d bad cycles expected 0", bad_fixed); end
    endtask

    task automatic test_delays(input int ad, input int wd);
        aw_dly = ad; w_dly = wd;
        snap; run_seq(fa, et, bo, gd, lat);
        n_checks++; if (gd !== 1'b1 || seq_bad(sa, sd) != 0) begin n_fail++; $display("FAIL delay_writes_%0d_%0d: done=%0d bad=%0d expected done=1 bad=0", ad, wd, gd, seq_bad(sa, sd)); end
        n_checks++; if (aw_hi - ah != (ad + 1) * m_len) begin n_fail++; $display("FAIL delay_awvalid_cycles_%0d_%0d: got %0d expected %0d", ad, wd, aw_hi - ah, (ad + 1) * m_len); end
        n_checks++; if (w_hi - wh != (wd + 1) * m_len) begin n_fail++; $display("FAIL delay_wvalid_cycles_%0d_%0d: got %0d expected %0d", ad, wd, w_hi - wh, (wd + 1) * m_len); end
        n_checks++; if (early_b - eb != 0) begin n_fail++; $display("FAIL delay_early_resp_%0d_%0d: got %0d expected 0", ad, wd, early_b - eb); end
        n_checks++; if (stab_viol - sv != 0) begin n_fail++; $display("FAIL delay_stability_%0d_%0d: got %0d expected 0", ad, wd, stab_viol - sv); end
        aw_dly = 0; w_dly = 0;
    endtask

    task automatic test_error;
        resp_plan[b_total % 256] = 2'b10;
        snap; run_seq(fa, et, bo, gd, lat);
        resp_plan[(b_total - 2) % 256] = 2'b00;
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL error_set: got %0d expected 1", error); end
        n_checks++; if (gd !== 1'b1 || seq_bad(sa, sd) != 0) begin n_fail++; $display("FAIL error_continues: done=%0d bad=%0d expected done=1 bad=0", gd, seq_bad(sa, sd)); end
        snap; run_seq(fa, et, bo, gd, lat);
        n_checks++; if (et !== 1'b0) begin n_fail++; $display("FAIL error_cleared_t1: got %0d expected 0", et); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL error_after_ok: got %0d expected 0", error); end
        m_err = 0;
    endtask

    task automatic test_overrun;
        int oc;
        bit ok;
        aw_dly = 2;
        snap; oc = ovr_total; ok = 0;
        trigger = 1; tick; trigger = 0; tick;
        trigger = 1; tick; trigger = 0;
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_pulse: got %0d expected 1", overrun); end
        cfg_we = 1; cfg_sel_count = 0; cfg_index = 0; cfg_address = 32'hDEAD_BEEF; cfg_data = 32'h1234_5678;
        tick; cfg_we = 0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_one_cycle: got %0d expected 0", overrun); end
        for (int i = 0; i < 400 && !ok; i++) begin if (done) ok = 1; else tick; end
        tick; tick;
        n_checks++; if (!ok || seq_bad(sa, sd) != 0 || done_total - dt != 1) begin n_fail++; $display("FAIL overrun_single_seq: done=%0d bad=%0d dones=%0d expected 1 0 1", ok, seq_bad(sa, sd), done_total - dt); end
        n_checks++; if (ovr_total - oc != 1) begin n_fail++; $display("FAIL overrun_count: got %0d expected 1", ovr_total - oc); end
        aw_dly = 0;
        snap; run_seq(fa, et, bo, gd, lat);
        n_checks++; if (gd !== 1'b1 || seq_bad(sa, sd) != 0) begin n_fail++; $display("FAIL cfg_busy_ignored: done=%0d bad=%0d expected done=1 bad=0", gd, seq_bad(sa, sd)); end
    endtask

    task automatic test_zero_sat;
        cfg_len(0);
        snap; run_seq(fa, et, bo, gd, lat);
        n_checks++; if (gd !== 1'b1 || lat != 0) begin n_fail++; $display("FAIL zero_len_done: done=%0d latency=%0d expected 1 0", gd, lat); end
        n_checks++; if (fa !== 1'b0 || aw_hi - ah != 0 || obs_addr.size() - sa != 0) begin n_fail++; $display("FAIL zero_len_no_bus: awvalid cycles=%0d expected 0", aw_hi - ah); end
        for (int j = 0; j < N; j++) cfg_entry(j, 32'h4000_0000 + 32'(j * 4), $urandom);
        cfg_len(20);
        snap; run_seq(fa, et, bo, gd, lat);
        n_checks++; if (gd !== 1'b1 || seq_bad(sa, sd) != 0) begin n_fail++; $display("FAIL len_saturate: writes=%0d bad=%0d expected writes=8 bad=0", obs_addr.size() - sa, seq_bad(sa, sd)); end
    endtask

    task automatic test_reset_mid;
        cfg_len(2);
        aw_dly = 3; w_dly = 3;
        trigger = 1; tick; trigger = 0;
        n_checks++; if (awvalid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: awvalid=%0d expected 1", awvalid); end
        reset = 1; tick;
        n_checks++; if ({awvalid, wvalid, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_drop: got %b expected 000", {awvalid, wvalid, busy}); end
        reset = 0; m_len = 0; m_err = 0; tick;
        aw_dly = 0; w_dly = 0;
        cfg_len(2);
        snap; run_seq(fa, et, bo, gd, lat);
        n_checks++; if (gd !== 1'b1 || seq_bad(sa, sd) != 0) begin n_fail++; $display("FAIL rst_mid_rerun: done=%0d bad=%0d expected done=1 bad=0", gd, seq_bad(sa, sd)); end
    endtask

    task automatic test_random;
        bit exp_err;
        int base;
        logic [1:0] r;
        for (int it = 0; it < 12; it++) begin
            for (int j = 0; j < N; j++) cfg_entry(j, $urandom, $urandom);
            cfg_len($urandom_range(0, 10));
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            exp_err = (m_len == 0) ? m_err : 1'b0;
            base = b_total;
            for (int j = 0; j < m_len; j++) begin
                r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                resp_plan[(base + j) % 256] = r;
                if (r != 2'b00) exp_err = 1;
            end
            snap; run_seq(fa, et, bo, gd, lat);
            for (int j = 0; j < m_len; j++) resp_plan[(base + j) % 256] = 2'b00;
            n_checks++; if (gd !== 1'b1 || seq_bad(sa, sd) != 0) begin n_fail++; $display("FAIL rand_writes_%0d: len=%0d done=%0d bad=%0d expected done=1 bad=0", it, m_len, gd, seq_bad(sa, sd)); end
            n_checks++; if (error !== exp_err) begin n_fail++; $display("FAIL rand_error_%0d: got %0d expected %0d", it, error, exp_err); end
            n_checks++; if (done_total - dt != 1) begin n_fail++; $display("FAIL rand_done_count_%0d: got %0d expected 1", it, done_total - dt); end
            m_err = exp_err;
        end
        aw_dly = 0; w_dly = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) resp_plan[i] = 2'b00;
        reset = 1; trigger = 0; cfg_we = 0; cfg_sel_count = 0;
        cfg_index = 0; cfg_address = 0; cfg_data = 0;
        test_reset;
        test_basic;
        test_delays(3, 0);
        test_delays(0, 3);
        test_error;
        test_overrun;
        test_zero_sat;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
